// File: rtl/l2_instr_refill_ctrl.sv
// Direct-mapped one-word-per-entry L2 that sits between the L1 I-cache miss
// port and main memory; hits return in two cycles, misses refill first.
module l2_instr_refill_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SETS   = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss_req_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  flush_i,
    output logic                  l2_cache_valid_o,
    output logic [DATA_WIDTH-1:0] l2_cache_data_o,
    output logic                  busy_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ready_i,
    input  logic                  mem_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOOKUP   = 3'd1;
    localparam logic [2:0] S_MEM_REQ  = 3'd2;
    localparam logic [2:0] S_MEM_WAIT = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [NUM_SETS-1:0]   valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [31:0]           hits_q;
    logic [31:0]           misses_q;

    logic [TAG_W-1:0]      tag_mem  [NUM_SETS];
    logic [DATA_WIDTH-1:0] data_mem [NUM_SETS];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic             fill;

    // The byte offset bits stay in the tag so unaligned addresses never alias.
    assign idx  = addr_q[IDX_W+1:2];
    assign tag  = {addr_q[ADDR_WIDTH-1:IDX_W+2], addr_q[1:0]};
    assign hit  = valid_q[idx] && (tag_mem[idx] == tag);
    assign fill = (state == S_MEM_WAIT) && mem_valid_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            valid_q  <= '0;
            data_q   <= '0;
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            // Flush wins over a same-cycle fill; the word is still returned.
            if (flush_i) begin
                valid_q <= '0;
            end else if (fill) begin
                valid_q[idx] <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (miss_req_i) begin
                        addr_q <= addr_i;
                        state  <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        hits_q <= hits_q + 32'd1;
                        data_q <= data_mem[idx];
                        state  <= S_RESP;
                    end else begin
                        misses_q <= misses_q + 32'd1;
                        state    <= S_MEM_REQ;
                    end
                end
                S_MEM_REQ: begin
                    if (mem_ready_i) begin
                        state <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_valid_i) begin
                        data_q <= mem_data_i;
                        state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= mem_data_i;
        end
    end

    assign l2_cache_valid_o = (state == S_RESP);
    assign l2_cache_data_o  = data_q;
    assign busy_o           = (state != S_IDLE);
    assign mem_req_o        = (state == S_MEM_REQ);
    assign mem_addr_o       = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign hit_count_o      = hits_q;
    assign miss_count_o     = misses_q;

endmodule

// File: tb/tb_l2_instr_refill_ctrl.sv
// Scenario bench for l2_instr_refill_ctrl: returned words are checked
// against a queue filled when each request is issued.
module tb_l2_instr_refill_ctrl;

    logic        clk;
    logic        rst_n;
    logic        miss_req_i;
    logic [31:0] addr_i;
    logic        flush_i;
    logic        l2_cache_valid_o;
    logic [31:0] l2_cache_data_o;
    logic        busy_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic        mem_valid_i;
    logic [31:0] mem_data_i;
    logic [31:0] hit_count_o;
    logic [31:0] miss_count_o;

    int          checks;
    int          errors;
    logic [31:0] sb[$];
    logic [31:0] exp_hits;
    logic [31:0] exp_miss;

    l2_instr_refill_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .miss_req_i       (miss_req_i),
        .addr_i           (addr_i),
        .flush_i          (flush_i),
        .l2_cache_valid_o (l2_cache_valid_o),
        .l2_cache_data_o  (l2_cache_data_o),
        .busy_o           (busy_o),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_ready_i      (mem_ready_i),
        .mem_valid_i      (mem_valid_i),
        .mem_data_i       (mem_data_i),
        .hit_count_o      (hit_count_o),
        .miss_count_o     (miss_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (l2_cache_valid_o === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse data=%h queue empty", l2_cache_data_o);
            end else begin
                logic [31:0] exp;
                exp = sb.pop_front();
                if (l2_cache_data_o !== exp) begin
                    errors++;
                    $display("FAIL resp_data got=%h exp=%h", l2_cache_data_o, exp);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a);
        @(posedge clk);
        #1;
        miss_req_i = 1'b1;
        addr_i     = a;
        @(posedge clk);
        #1;
        miss_req_i = 1'b0;
        addr_i     = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_hits = 0;
        exp_miss = 0;
        @(negedge clk);
        checks++;
        if ({l2_cache_valid_o, busy_o, mem_req_o} !== 3'b000 ||
            l2_cache_data_o !== 32'h0 || mem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs v=%b b=%b r=%b d=%h a=%h exp all 0",
                     l2_cache_valid_o, busy_o, mem_req_o, l2_cache_data_o, mem_addr_o);
        end
        checks++;
        if (hit_count_o !== 32'h0 || miss_count_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_counters h=%0d m=%0d exp 0 0", hit_count_o, miss_count_o);
        end
    endtask

    task automatic do_miss(input logic [31:0] a, input logic [31:0] d,
                           input int rdy_dly, input int vld_dly, input logic fl);
        sb.push_back(d);
        exp_miss++;
        issue(a);
        @(negedge clk);
        checks++;
        if (mem_req_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL miss_lookup req=%b busy=%b exp 0 1", mem_req_o, busy_o);
        end
        @(negedge clk);
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== {a[31:2], 2'b00}) begin
            errors++;
            $display("FAIL miss_req req=%b addr=%h exp 1 %h", mem_req_o, mem_addr_o,
                     {a[31:2], 2'b00});
        end
        checks++;
        if (miss_count_o !== exp_miss || hit_count_o !== exp_hits) begin
            errors++;
            $display("FAIL miss_counts m=%0d h=%0d exp %0d %0d", miss_count_o,
                     hit_count_o, exp_miss, exp_hits);
        end
        repeat (rdy_dly) @(posedge clk);
        #1;
        mem_ready_i = 1'b1;
        @(posedge clk);
        #1;
        mem_ready_i = 1'b0;
        repeat (vld_dly - 1) @(posedge clk);
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || l2_cache_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL miss_wait req=%b v=%b exp 0 0", mem_req_o, l2_cache_valid_o);
        end
        mem_valid_i = 1'b1;
        mem_data_i  = d;
        flush_i     = fl;
        @(posedge clk);
        #1;
        mem_valid_i = 1'b0;
        mem_data_i  = 32'h0;
        flush_i     = 1'b0;
        @(negedge clk);
        checks++;
        if (l2_cache_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL miss_pulse v=%b exp 1", l2_cache_valid_o);
        end
    endtask

    task automatic do_hit(input logic [31:0] a, input logic [31:0] d);
        sb.push_back(d);
        exp_hits++;
        issue(a);
        @(negedge clk);
        checks++;
        if (l2_cache_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL hit_lookup v=%b busy=%b exp 0 1", l2_cache_valid_o, busy_o);
        end
        @(negedge clk);
        checks++;
        if (l2_cache_valid_o !== 1'b1 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL hit_pulse v=%b req=%b exp 1 0", l2_cache_valid_o, mem_req_o);
        end
        checks++;
        if (hit_count_o !== exp_hits || miss_count_o !== exp_miss) begin
            errors++;
            $display("FAIL hit_counts h=%0d m=%0d exp %0d %0d", hit_count_o,
                     miss_count_o, exp_hits, exp_miss);
        end
        @(negedge clk);
        checks++;
        if (l2_cache_valid_o !== 1'b0 || busy_o !== 1'b0 || l2_cache_data_o !== d) begin
            errors++;
            $display("FAIL hit_after v=%b busy=%b d=%h exp 0 0 %h", l2_cache_valid_o,
                     busy_o, l2_cache_data_o, d);
        end
    endtask

    task automatic test_cold_miss();
        do_miss(32'hBFC0_0000, 32'h0FF0_0313, 3, 2, 1'b0);
        @(negedge clk);
        checks++;
        if (l2_cache_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL cold_single_pulse v=%b busy=%b exp 0 0", l2_cache_valid_o, busy_o);
        end
    endtask

    task automatic test_hit();
        do_hit(32'hBFC0_0000, 32'h0FF0_0313);
    endtask

    task automatic test_conflict();
        do_miss(32'hBFC0_1000, 32'hDEAD_BEEF, 1, 1, 1'b0);
        do_miss(32'hBFC0_0000, 32'h0FF0_0313, 0, 3, 1'b0);
        do_hit(32'hBFC0_0000, 32'h0FF0_0313);
    endtask

    task automatic test_flush_idle();
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        do_miss(32'hBFC0_0000, 32'h0FF0_0313, 2, 1, 1'b0);
    endtask

    task automatic test_flush_on_fill();
        do_miss(32'h0000_0104, 32'h1111_1111, 1, 2, 1'b1);
        do_miss(32'h0000_0104, 32'h2222_2222, 1, 1, 1'b0);
        do_hit(32'h0000_0104, 32'h2222_2222);
    endtask

    task automatic test_back_to_back();
        do_miss(32'h0000_2000, 32'hAAAA_0001, 0, 1, 1'b0);
        do_miss(32'h0000_3004, 32'hBBBB_0002, 1, 1, 1'b0);
        do_miss(32'h0000_2001, 32'hCCCC_0003, 0, 2, 1'b0);
        do_hit(32'h0000_3004, 32'hBBBB_0002);
        do_hit(32'h0000_2001, 32'hCCCC_0003);
    endtask

    task automatic test_reset_midfill();
        issue(32'h0000_0400);
        repeat (2) @(posedge clk);
        #1;
        mem_ready_i = 1'b1;
        @(posedge clk);
        #1;
        mem_ready_i = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_hits = 0;
        exp_miss = 0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({l2_cache_valid_o, busy_o, mem_req_o} !== 3'b000) begin
                errors++;
                $display("FAIL midfill_reset v=%b busy=%b req=%b exp 0 0 0",
                         l2_cache_valid_o, busy_o, mem_req_o);
            end
        end
        do_miss(32'h0000_0400, 32'h5555_AAAA, 1, 1, 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        miss_req_i  = 1'b0;
        addr_i      = 32'h0;
        flush_i     = 1'b0;
        mem_ready_i = 1'b0;
        mem_valid_i = 1'b0;
        mem_data_i  = 32'h0;
        checks      = 0;
        errors      = 0;
        exp_hits    = 0;
        exp_miss    = 0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush_idle();
        test_flush_on_fill();
        test_back_to_back();
        test_reset_midfill();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_responses pending=%0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
